uart_receiver: RTL and testbench

- Asynchronous serial receiver: 8N1 frames (1 start, 8 data LSB-first, 1 stop) on `rx`, oversampled 16x using the `clk_en` tick.
- Delivers the byte on `data` and raises the sticky `rdy` flag until the consumer clears it with `rdy_clr`.
- Sits between the board RX pin and the byte-consuming logic. A baud generator supplies `clk_en` at 16x the baud rate.

---
 rtl/uart_receiver_if.sv | 30 +++
 rtl/uart_receiver.sv | 135 +++++++++++++
 tb/tb_uart_receiver.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// Byte-side and line-side signals of the 8N1 UART receiver.
`timescale 1ns/1ps

interface uart_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 clk_en;   // sample tick, OVERSAMPLE x baud
  logic                 rx;       // raw serial line, idle high
  logic                 rdy_clr;  // consumer acknowledge
  logic                 rdy;      // sticky byte-available flag
  logic [DATA_BITS-1:0] data;     // last valid received byte

  // Baud source, line and byte consumer.
  modport master (
    output clk_en,
    output rx,
    output rdy_clr,
    input  rdy,
    input  data
  );

  // Receiver side.
  modport slave (
    input  clk_en,
    input  rx,
    input  rdy_clr,
    output rdy,
    output data
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 asynchronous serial receiver, oversampled by clk_en ticks, with a
// sticky ready flag that the consumer acknowledges through rdy_clr.
`timescale 1ns/1ps

module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_receiver_if.slave  bus
);

  localparam int unsigned SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MID  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t                 state_q;
  logic [SAMPLE_W-1:0]    sample_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   rdy_q;
  logic                   rx_meta_q;
  logic                   rx_sync_q;

  // Two-flop synchronizer for the asynchronous line; presets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame FSM: advances on ticks only; rdy_clr acts every edge, a
  // same-edge set overrides it so a freshly received byte is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sample_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      if (bus.rdy_clr) begin
        rdy_q <= 1'b0;
      end

      if (bus.clk_en) begin
        case (state_q)
          ST_IDLE: begin
            if (!rx_sync_q) begin
              state_q  <= ST_START;
              sample_q <= '0;
            end
          end

          ST_START: begin
            sample_q <= sample_q + SAMPLE_W'(1);
            if (sample_q == SAMPLE_MID && rx_sync_q) begin
              // Line returned high by mid-bit: glitch, not a start bit.
              state_q  <= ST_IDLE;
              sample_q <= '0;
            end else if (sample_q == SAMPLE_LAST) begin
              state_q   <= ST_DATA;
              sample_q  <= '0;
              bit_idx_q <= '0;
            end
          end

          ST_DATA: begin
            sample_q <= sample_q + SAMPLE_W'(1);
            if (sample_q == SAMPLE_MID) begin
              shift_q[bit_idx_q] <= rx_sync_q;
            end
            if (sample_q == SAMPLE_LAST) begin
              sample_q <= '0;
              if (bit_idx_q == IDX_LAST) begin
                state_q <= ST_STOP;
              end else begin
                bit_idx_q <= bit_idx_q + IDX_W'(1);
              end
            end
          end

          ST_STOP: begin
            sample_q <= sample_q + SAMPLE_W'(1);
            if (sample_q == SAMPLE_MID) begin
              sample_q <= '0;
              if (rx_sync_q) begin
                // Leave at mid stop bit so a back-to-back start edge is caught.
                data_q  <= shift_q;
                rdy_q   <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                // Framing error or break: drop the byte, wait for idle line.
                state_q <= ST_WAIT_HIGH;
              end
            end
          end

          ST_WAIT_HIGH: begin
            if (rx_sync_q) begin
              state_q <= ST_IDLE;
            end
          end

          default: begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rdy  = rdy_q;
  assign bus.data = data_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver against a byte-level
// reference model (expected byte and ready flag tracked per frame).
`timescale 1ns/1ps

module tb_uart_receiver;

  localparam int unsigned OS = 16;
  localparam int unsigned DB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned en_div = 2;     // clk_en high one clk in en_div; 0 holds it low
  int unsigned en_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state: what the consumer should see.
  logic [DB-1:0] exp_data;
  logic          exp_rdy;

  uart_receiver_if #(.DATA_BITS(DB)) bus ();

  uart_receiver #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Sample-tick generator, driven off the active edge.
  initial begin
    bus.clk_en = 1'b0;
    forever begin
      @(negedge clk);
      if (en_div == 0) begin
        bus.clk_en = 1'b0;
        en_cnt     = 0;
      end else begin
        bus.clk_en = (en_cnt == 0);
        en_cnt     = (en_cnt + 1 >= en_div) ? 0 : en_cnt + 1;
      end
    end
  end

  // Global time bound.
  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_rdy"},  32'(bus.rdy),  32'(exp_rdy));
    check({tag, "_data"}, 32'(bus.data), 32'(exp_data));
  endtask

  task automatic wait_ticks(input int unsigned n);
    int unsigned d;
    d = (en_div == 0) ? 1 : en_div;
    repeat (n * d) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    wait_ticks(OS);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.rdy_clr = 1'b1;
    @(negedge clk);
    bus.rdy_clr = 1'b0;
    exp_rdy = 1'b0;
  endtask

  // One 8N1 frame. A bad stop leaves rx low; the caller releases it.
  // With clr_at_set, rdy_clr is held through the stop bit and dropped just
  // after the edge that delivers the byte, so clear and set coincide.
  task automatic send_frame(input logic [DB-1:0] b, input bit good_stop, input bit clr_at_set);
    bit          found;
    int unsigned limit;
    send_bit(1'b0);
    for (int i = 0; i < int'(DB); i++) begin
      send_bit(b[i]);
      if (i == 3) check("no_partial", 32'(bus.data), 32'(exp_data));
    end
    if (good_stop) begin
      bus.rx = 1'b1;
      if (clr_at_set) begin
        found       = 1'b0;
        limit       = OS * en_div;
        bus.rdy_clr = 1'b1;
        for (int unsigned k = 0; k < limit; k++) begin
          @(posedge clk);
          #1;
          if (bus.data === b) begin
            found = 1'b1;
            break;
          end
        end
        bus.rdy_clr = 1'b0;
        check("set_edge_seen", 32'(found), 32'd1);
        check("set_wins_over_clr", 32'(bus.rdy), 32'd1);
      end
      wait_ticks(OS);
      exp_data = b;
      exp_rdy  = 1'b1;
    end else begin
      send_bit(1'b0);
    end
  endtask

  initial begin
    logic [DB-1:0] b;
    bit            bad;

    bus.rx      = 1'b1;
    bus.rdy_clr = 1'b0;
    exp_data    = '0;
    exp_rdy     = 1'b0;

    // Reset state.
    repeat (5) @(negedge clk);
    check_out("reset");
    rst_n = 1'b1;

    // Idle line, ticks every other clk.
    repeat (2000) @(negedge clk);
    check_out("idle");

    // Single frame and acknowledge.
    send_frame(8'hA5, 1'b1, 1'b0);
    check_out("a5");
    pulse_clr();
    check_out("a5_clr");

    // False start, then a real frame.
    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(2 * OS);
    check_out("false_start");
    send_frame(8'h3C, 1'b1, 1'b0);
    check_out("3c");
    pulse_clr();

    // Framing error with line held low (40 ticks incl. stop bit).
    send_frame(8'h55, 1'b0, 1'b0);
    wait_ticks(40 - OS);
    bus.rx = 1'b1;
    wait_ticks(OS);
    check_out("break");
    send_frame(8'h0F, 1'b1, 1'b0);
    check_out("0f");

    // Back-to-back frames, second set coinciding with rdy_clr.
    send_frame(8'h12, 1'b1, 1'b0);
    check_out("b2b_first");
    send_frame(8'h34, 1'b1, 1'b1);
    check_out("b2b_second");

    // Ticks stopped: line activity ignored, rdy_clr still effective.
    en_div = 0;
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (100) @(negedge clk);
    bus.rx = 1'b1;
    pulse_clr();
    repeat (10) @(negedge clk);
    check_out("frozen");
    en_div = 2;
    wait_ticks(2 * OS);
    check_out("unfrozen");

    // Reset in the middle of the data bits.
    send_frame(8'h99, 1'b1, 1'b0);
    check_out("pre_reset");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    exp_data = '0;
    exp_rdy  = 1'b0;
    check_out("reset_mid");
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(OS);
    check_out("after_reset");
    send_frame(8'hC3, 1'b1, 1'b0);
    check_out("c3");

    // Randomized frames, tick rates, gaps, framing errors and acknowledges.
    for (int r = 0; r < 24; r++) begin
      en_div = $urandom_range(1, 4);
      bus.rx = 1'b1;
      wait_ticks($urandom_range(0, 20));
      b   = DB'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad, 1'b0);
      if (bad) begin
        wait_ticks($urandom_range(0, 30));
        bus.rx = 1'b1;
        wait_ticks(OS);
      end
      check_out("rnd");
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_out("rnd_clr");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
